alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
- ALU reservation station; the issuing side of the ALU execute interface.
- Buffers dispatched ALU/branch/address ops with operand values or ROB tags.
- Wakes waiting operands by snooping the ALU and LSB result broadcasts.
- Issues at most one ready op per cycle to the ALU as a registered execute pulse with type, val1, val2, entry and nowPC.

Parameters:
- RS_SIZE, 8, number of entries; power of two, at least 2.
- ROB_ID_WIDTH, 4, ROB tag width; matches the shared constant.
- OP_WIDTH, 7, op type code width; [6:4] class, [3:1] funct, [0] variant.
- VAL_WIDTH, 32, operand/result width.
- ADDR_WIDTH, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_in  in  1  asynchronous active-low reset; 0 = reset asserted.
- rdy_in  in  1  global enable; 0 = hold all state and outputs.
- flush  in  1  mispredict clear; synchronous.
- disp_valid  in  1  dispatch request this cycle.
- disp_type  in  OP_WIDTH  op code.
- disp_q1_rdy  in  1  operand 1 value valid.
- disp_v1  in  VAL_WIDTH  operand 1 value.
- disp_q1  in  ROB_ID_WIDTH  operand 1 producer tag.
- disp_q2_rdy  in  1  operand 2 value valid.
- disp_v2  in  VAL_WIDTH  operand 2 value.
- disp_q2  in  ROB_ID_WIDTH  operand 2 producer tag.
- disp_entry  in  ROB_ID_WIDTH  destination ROB tag.
- disp_pc  in  ADDR_WIDTH  value forwarded as nowPC.
- rs_full  out  1  no free entry; registered-count based.
- alu_ready  in  1  ALU broadcast valid.
- alu_entry  in  ROB_ID_WIDTH  ALU broadcast tag.
- alu_val  in  VAL_WIDTH  ALU broadcast value.
- lsb_ready  in  1  LSB broadcast valid.
- lsb_entry  in  ROB_ID_WIDTH  LSB broadcast tag.
- lsb_val  in  VAL_WIDTH  LSB broadcast value.
- execute  out  1  one-cycle issue pulse to ALU.
- type  out  OP_WIDTH  issued op code.
- val1  out  VAL_WIDTH  issued operand 1.
- val2  out  VAL_WIDTH  issued operand 2.
- entry  out  ROB_ID_WIDTH  issued ROB tag.
- nowPC  out  ADDR_WIDTH  issued PC.

Behaviour:
- Reset (rst_in=0, asynchronous): all entries not busy; count 0; rs_full=0; execute=0; type, val1, val2, entry and nowPC all 0.
- rdy_in=0: no state or output change, including execute. This matches the ALU, which also freezes, so a held pulse is consumed exactly once.
- Entry state: busy, type, q1_rdy, v1, q1, q2_rdy, v2, q2, dest, pc.
- Dispatch (disp_valid=1, rs_full=0, no flush): write into the lowest-index non-busy entry, using busy flags from before the edge.
  - Dispatch while rs_full=1 is ignored; the bench flags it as a protocol violation.
- Dispatch bypass: if a dispatched operand is not ready and its tag equals a same-cycle broadcast tag, capture that broadcast value and store the operand as ready. ALU broadcast has priority over LSB if both match.
- Wakeup, every edge, for each busy entry and operand: not ready and tag==alu_entry with alu_ready → load alu_val and set ready. Same rule for LSB. An entry woken at edge N is issue-eligible from edge N+1.
- Select: at each edge, take the lowest-index entry that is busy, has both operands ready and was valid before the edge.
  - execute<=1; type, val1, val2, entry and nowPC are loaded from that entry; the entry's busy is cleared.
  - If no entry is eligible: execute<=0, other outputs hold.
- Latency: dispatch with both operands ready at edge N → execute high in cycle after edge N+1 → ALU result broadcast after edge N+2.
- An entry freed at edge N is not reallocated at edge N; it is available from N+1.
- Count update: count_next = count + accepted_dispatch − issued. rs_full = (count == RS_SIZE).
- Flush (priority over dispatch, wakeup and select): clear all busy, count<=0, execute<=0. Dispatch in the same cycle is dropped.
- No ordering guarantee beyond lowest-index-first; older-first is not required.

Decomposition:
- Shared package/util header: OP_WIDTH, VAL_WIDTH, ROB_ID_WIDTH, ADDR_WIDTH, op class codes (OP_B_TYPE, OP_I_TYPE, OP_L_TYPE, OP_S_TYPE, OP_R_TYPE).
- Sub-module rs_first_one: parameterised lowest-index priority encoder (RS_SIZE bits in; index plus found flag out). Instantiated twice: once for the free-slot search, once for the ready-slot search.

Test Plan:
1. Hold rst_in=0, then release. Dispatch addi (type I/000) with v1=5, v2=7, entry=3, pc=0x100, both ready → exactly one execute pulse two edges later with val1=5, val2=7, entry=3, nowPC=0x100; rs_full=0 throughout.
2. Dispatch with q1=2 not ready and v2=1 ready; two cycles later alu_ready=1, alu_entry=2, alu_val=0x10 → execute in the cycle after the next edge with val1=0x10, val2=1.
3. Dispatch with q2=5 not ready while lsb_ready=1, lsb_entry=5, lsb_val=0xAB in the same cycle → issued with val2=0xAB; no hang.
4. Dispatch 8 ops all waiting on tag 7 → rs_full=1; a 9th dispatch is ignored. Broadcast tag 7 → 8 consecutive execute pulses in slot order 0..7, then rs_full=0 and execute=0.
5. With 4 entries pending, assert flush together with disp_valid → next cycle execute=0, rs_full=0. A later broadcast of the pending tags produces no issue.
6. Drop rdy_in to 0 for 3 cycles while execute=1 with entry=4 → execute and all fields held unchanged. After rdy_in returns to 1, the next eligible op issues with no duplicate and no loss.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared constants and types for the ALU reservation station.
// Holds the op/value/tag/PC widths, the op class codes carried in op[6:4],
// the operand and entry record layouts, and the broadcast snoop helper used
// by both dispatch bypass and wakeup.
package alu_rs_pkg;

    localparam int unsigned OP_WIDTH     = 7;
    localparam int unsigned VAL_WIDTH    = 32;
    localparam int unsigned ROB_ID_WIDTH = 4;
    localparam int unsigned ADDR_WIDTH   = 32;

    // Op class lives in op[6:4]; op[3:1] is funct, op[0] the variant bit.
    typedef enum logic [2:0] {
        OP_B_TYPE = 3'd1,
        OP_I_TYPE = 3'd2,
        OP_L_TYPE = 3'd3,
        OP_S_TYPE = 3'd4,
        OP_R_TYPE = 3'd5
    } op_class_e;

    typedef struct packed {
        logic                    rdy;
        logic [ROB_ID_WIDTH-1:0] tag;
        logic [VAL_WIDTH-1:0]    val;
    } operand_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0]     op;
        operand_t                src1;
        operand_t                src2;
        logic [ROB_ID_WIDTH-1:0] dest;
        logic [ADDR_WIDTH-1:0]   pc;
    } rs_entry_t;

    // Capture a broadcast result into a waiting operand; ALU wins over LSB.
    function automatic operand_t snoop(
        input operand_t                opnd,
        input logic                    alu_ready,
        input logic [ROB_ID_WIDTH-1:0] alu_entry,
        input logic [VAL_WIDTH-1:0]    alu_val,
        input logic                    lsb_ready,
        input logic [ROB_ID_WIDTH-1:0] lsb_entry,
        input logic [VAL_WIDTH-1:0]    lsb_val
    );
        operand_t res;
        res = opnd;
        if (!opnd.rdy) begin
            if (alu_ready && (opnd.tag == alu_entry)) begin
                res.rdy = 1'b1;
                res.val = alu_val;
            end else if (lsb_ready && (opnd.tag == lsb_entry)) begin
                res.rdy = 1'b1;
                res.val = lsb_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_first_one.sv
// Lowest-index priority encoder.
// Ports:
//   req_i   - request vector, bit i set when slot i qualifies
//   idx_o   - index of the lowest set bit (0 when none)
//   found_o - at least one bit of req_i is set
module rs_first_one #(
    parameter int unsigned Width = 8,
    localparam int unsigned IdxW = $clog2(Width)
) (
    input  logic [Width-1:0] req_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             found_o
);

    // Scan high to low so the last hit written is the lowest index.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = Width - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = IdxW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: buffers dispatched ALU/branch/address ops, wakes
// waiting operands from the ALU and LSB result broadcasts, and issues at most
// one ready op per cycle as a registered execute pulse.
// Ports:
//   clk, rst_in (async active-low), rdy_in (global enable), flush (sync clear)
//   disp_*      - dispatch request, op code, operands/tags, dest tag, PC
//   rs_full     - no free entry (from the registered occupancy count)
//   alu_*/lsb_* - result broadcasts snooped for wakeup and dispatch bypass
//   execute     - one-cycle issue pulse; op_type/val1/val2/entry/nowPC hold
//                 the last issued op
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int unsigned RS_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    disp_valid,
    input  logic [OP_WIDTH-1:0]     disp_type,
    input  logic                    disp_q1_rdy,
    input  logic [VAL_WIDTH-1:0]    disp_v1,
    input  logic [ROB_ID_WIDTH-1:0] disp_q1,
    input  logic                    disp_q2_rdy,
    input  logic [VAL_WIDTH-1:0]    disp_v2,
    input  logic [ROB_ID_WIDTH-1:0] disp_q2,
    input  logic [ROB_ID_WIDTH-1:0] disp_entry,
    input  logic [ADDR_WIDTH-1:0]   disp_pc,
    output logic                    rs_full,
    input  logic                    alu_ready,
    input  logic [ROB_ID_WIDTH-1:0] alu_entry,
    input  logic [VAL_WIDTH-1:0]    alu_val,
    input  logic                    lsb_ready,
    input  logic [ROB_ID_WIDTH-1:0] lsb_entry,
    input  logic [VAL_WIDTH-1:0]    lsb_val,
    output logic                    execute,
    output logic [OP_WIDTH-1:0]     op_type,
    output logic [VAL_WIDTH-1:0]    val1,
    output logic [VAL_WIDTH-1:0]    val2,
    output logic [ROB_ID_WIDTH-1:0] entry,
    output logic [ADDR_WIDTH-1:0]   nowPC
);

    localparam int unsigned IdxW = $clog2(RS_SIZE);
    localparam int unsigned CntW = $clog2(RS_SIZE + 1);

    logic      [RS_SIZE-1:0] busy_q, busy_d;
    rs_entry_t [RS_SIZE-1:0] ent_q, ent_d;
    logic      [CntW-1:0]    count_q, count_d;

    logic                    exec_q, exec_d;
    logic [OP_WIDTH-1:0]     op_q, op_d;
    logic [VAL_WIDTH-1:0]    val1_q, val1_d;
    logic [VAL_WIDTH-1:0]    val2_q, val2_d;
    logic [ROB_ID_WIDTH-1:0] dest_q, dest_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;

    logic [RS_SIZE-1:0] ready_vec;
    logic [IdxW-1:0]    free_idx, sel_idx;
    logic               free_found, sel_found;
    logic               accept, issue;
    rs_entry_t          new_ent;
    operand_t           disp_op1, disp_op2;

    assign rs_full = (count_q == CntW'(RS_SIZE));

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy_q[i] && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
        end
    end

    // Both searches look only at pre-edge state, so a slot freed by this
    // edge's issue is not reallocated until the next edge.
    rs_first_one #(.Width(RS_SIZE)) u_free_search (
        .req_i   (~busy_q),
        .idx_o   (free_idx),
        .found_o (free_found)
    );

    rs_first_one #(.Width(RS_SIZE)) u_ready_search (
        .req_i   (ready_vec),
        .idx_o   (sel_idx),
        .found_o (sel_found)
    );

    assign accept = rdy_in && !flush && disp_valid && !rs_full && free_found;
    assign issue  = rdy_in && !flush && sel_found;

    always_comb begin
        disp_op1.rdy = disp_q1_rdy;
        disp_op1.tag = disp_q1;
        disp_op1.val = disp_v1;
        disp_op2.rdy = disp_q2_rdy;
        disp_op2.tag = disp_q2;
        disp_op2.val = disp_v2;
        new_ent.op   = disp_type;
        new_ent.src1 = snoop(disp_op1, alu_ready, alu_entry, alu_val,
                             lsb_ready, lsb_entry, lsb_val);
        new_ent.src2 = snoop(disp_op2, alu_ready, alu_entry, alu_val,
                             lsb_ready, lsb_entry, lsb_val);
        new_ent.dest = disp_entry;
        new_ent.pc   = disp_pc;
    end

    always_comb begin
        busy_d  = busy_q;
        ent_d   = ent_q;
        count_d = count_q;
        exec_d  = exec_q;
        op_d    = op_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        dest_d  = dest_q;
        pc_d    = pc_q;

        if (rdy_in) begin
            if (flush) begin
                busy_d  = '0;
                count_d = '0;
                exec_d  = 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i]) begin
                        ent_d[i].src1 = snoop(ent_q[i].src1, alu_ready, alu_entry, alu_val,
                                              lsb_ready, lsb_entry, lsb_val);
                        ent_d[i].src2 = snoop(ent_q[i].src2, alu_ready, alu_entry, alu_val,
                                              lsb_ready, lsb_entry, lsb_val);
                    end
                end

                exec_d = issue;
                if (issue) begin
                    busy_d[sel_idx] = 1'b0;
                    op_d            = ent_q[sel_idx].op;
                    val1_d          = ent_q[sel_idx].src1.val;
                    val2_d          = ent_q[sel_idx].src2.val;
                    dest_d          = ent_q[sel_idx].dest;
                    pc_d            = ent_q[sel_idx].pc;
                end

                // Free slot is never the issuing slot: one is busy, the other not.
                if (accept) begin
                    busy_d[free_idx] = 1'b1;
                    ent_d[free_idx]  = new_ent;
                end

                if (accept && !issue) begin
                    count_d = count_q + CntW'(1);
                end else if (!accept && issue) begin
                    count_d = count_q - CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            busy_q  <= '0;
            ent_q   <= '0;
            count_q <= '0;
            exec_q  <= 1'b0;
            op_q    <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            dest_q  <= '0;
            pc_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            ent_q   <= ent_d;
            count_q <= count_d;
            exec_q  <= exec_d;
            op_q    <= op_d;
            val1_q  <= val1_d;
            val2_q  <= val2_d;
            dest_q  <= dest_d;
            pc_q    <= pc_d;
        end
    end

    assign execute = exec_q;
    assign op_type = op_q;
    assign val1    = val1_q;
    assign val2    = val2_q;
    assign entry   = dest_q;
    assign nowPC   = pc_q;

endmodule

// File: tb/tb_alu_rs.sv
// Self-checking bench for alu_rs: directed scenarios followed by randomized
// traffic, all compared against a slot-level behavioural model.
module tb_alu_rs;
    import alu_rs_pkg::*;

    localparam int RS = 8;

    logic        clk = 1'b0;
    logic        rst_in, rdy_in, flush;
    logic        disp_valid, disp_q1_rdy, disp_q2_rdy;
    logic [6:0]  disp_type;
    logic [31:0] disp_v1, disp_v2, disp_pc;
    logic [3:0]  disp_q1, disp_q2, disp_entry;
    logic        rs_full;
    logic        alu_ready, lsb_ready;
    logic [3:0]  alu_entry, lsb_entry;
    logic [31:0] alu_val, lsb_val;
    logic        execute;
    logic [6:0]  op_type;
    logic [31:0] val1, val2, nowPC;
    logic [3:0]  entry;

    int checks = 0;
    int errors = 0;

    // Behavioural model: one record per slot plus the issue output registers.
    logic        m_busy [RS];
    logic [6:0]  m_op   [RS];
    logic        m_r1   [RS];
    logic        m_r2   [RS];
    logic [31:0] m_v1   [RS];
    logic [31:0] m_v2   [RS];
    logic [3:0]  m_t1   [RS];
    logic [3:0]  m_t2   [RS];
    logic [3:0]  m_dest [RS];
    logic [31:0] m_pc   [RS];
    logic        m_exec;
    logic [6:0]  m_type;
    logic [31:0] m_val1, m_val2, m_nowpc;
    logic [3:0]  m_entry;

    alu_rs #(.RS_SIZE(RS)) dut (
        .clk         (clk),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_type   (disp_type),
        .disp_q1_rdy (disp_q1_rdy),
        .disp_v1     (disp_v1),
        .disp_q1     (disp_q1),
        .disp_q2_rdy (disp_q2_rdy),
        .disp_v2     (disp_v2),
        .disp_q2     (disp_q2),
        .disp_entry  (disp_entry),
        .disp_pc     (disp_pc),
        .rs_full     (rs_full),
        .alu_ready   (alu_ready),
        .alu_entry   (alu_entry),
        .alu_val     (alu_val),
        .lsb_ready   (lsb_ready),
        .lsb_entry   (lsb_entry),
        .lsb_val     (lsb_val),
        .execute     (execute),
        .op_type     (op_type),
        .val1        (val1),
        .val2        (val2),
        .entry       (entry),
        .nowPC       (nowPC)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_full();
        int n = 0;
        for (int i = 0; i < RS; i++) n += m_busy[i] ? 1 : 0;
        return n == RS;
    endfunction

    // Does a broadcast this cycle carry tag t? ALU takes precedence.
    function automatic bit bcast_hit(input logic [3:0] t, output logic [31:0] v);
        v = '0;
        if (alu_ready && alu_entry == t) begin v = alu_val; return 1'b1; end
        if (lsb_ready && lsb_entry == t) begin v = lsb_val; return 1'b1; end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) begin
            m_busy[i] = 1'b0; m_op[i] = '0; m_r1[i] = 1'b0; m_r2[i] = 1'b0;
            m_v1[i] = '0; m_v2[i] = '0; m_t1[i] = '0; m_t2[i] = '0;
            m_dest[i] = '0; m_pc[i] = '0;
        end
        m_exec = 1'b0; m_type = '0; m_val1 = '0; m_val2 = '0; m_entry = '0; m_nowpc = '0;
    endtask

    // Advance the model by one rising edge using the inputs now applied.
    task automatic model_edge();
        int sel = -1;
        int fre = -1;
        bit full0;
        logic [31:0] bv;
        if (!rdy_in) return;
        if (flush) begin
            for (int i = 0; i < RS; i++) m_busy[i] = 1'b0;
            m_exec = 1'b0;
            return;
        end
        full0 = model_full();
        if (disp_valid && full0) $display("note: dispatch while rs_full (protocol violation, dropped)");
        for (int i = 0; i < RS; i++) begin
            if (sel < 0 && m_busy[i] && m_r1[i] && m_r2[i]) sel = i;
            if (fre < 0 && !m_busy[i]) fre = i;
        end
        for (int i = 0; i < RS; i++) begin
            if (m_busy[i] && !m_r1[i] && bcast_hit(m_t1[i], bv)) begin m_r1[i] = 1'b1; m_v1[i] = bv; end
            if (m_busy[i] && !m_r2[i] && bcast_hit(m_t2[i], bv)) begin m_r2[i] = 1'b1; m_v2[i] = bv; end
        end
        if (sel >= 0) begin
            m_exec = 1'b1; m_type = m_op[sel]; m_val1 = m_v1[sel]; m_val2 = m_v2[sel];
            m_entry = m_dest[sel]; m_nowpc = m_pc[sel]; m_busy[sel] = 1'b0;
        end else begin
            m_exec = 1'b0;
        end
        if (disp_valid && !full0 && fre >= 0) begin
            m_busy[fre] = 1'b1; m_op[fre] = disp_type; m_dest[fre] = disp_entry;
            m_pc[fre] = disp_pc; m_t1[fre] = disp_q1; m_t2[fre] = disp_q2;
            m_r1[fre] = disp_q1_rdy; m_v1[fre] = disp_v1;
            m_r2[fre] = disp_q2_rdy; m_v2[fre] = disp_v2;
            if (!disp_q1_rdy && bcast_hit(disp_q1, bv)) begin m_r1[fre] = 1'b1; m_v1[fre] = bv; end
            if (!disp_q2_rdy && bcast_hit(disp_q2, bv)) begin m_r2[fre] = 1'b1; m_v2[fre] = bv; end
        end
    endtask

    task automatic check_outputs();
        chk("execute", execute, m_exec);
        chk("rs_full", rs_full, model_full());
        chk("type", op_type, m_type);
        chk("val1", val1, m_val1);
        chk("val2", val2, m_val2);
        chk("entry", entry, m_entry);
        chk("nowPC", nowPC, m_nowpc);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        disp_valid = 1'b0; flush = 1'b0; alu_ready = 1'b0; lsb_ready = 1'b0;
    endtask

    task automatic dispatch(input logic [6:0] t, input logic r1, input logic [31:0] v1,
                            input logic [3:0] q1, input logic r2, input logic [31:0] v2,
                            input logic [3:0] q2, input logic [3:0] dst, input logic [31:0] pc);
        disp_valid = 1'b1; disp_type = t;
        disp_q1_rdy = r1; disp_v1 = v1; disp_q1 = q1;
        disp_q2_rdy = r2; disp_v2 = v2; disp_q2 = q2;
        disp_entry = dst; disp_pc = pc;
    endtask

    initial begin
        logic [6:0] addi;
        addi = {3'(OP_I_TYPE), 3'b000, 1'b0};

        rst_in = 1'b0; rdy_in = 1'b1; idle();
        disp_type = '0; disp_q1_rdy = 1'b0; disp_v1 = '0; disp_q1 = '0;
        disp_q2_rdy = 1'b0; disp_v2 = '0; disp_q2 = '0; disp_entry = '0; disp_pc = '0;
        alu_entry = '0; alu_val = '0; lsb_entry = '0; lsb_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_in = 1'b1;

        // 1: both operands ready, issue two edges after dispatch
        dispatch(addi, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0, 4'd3, 32'h100);
        cycle();
        chk("t1_no_early_exec", execute, 1'b0);
        idle();
        cycle();
        chk("t1_exec", execute, 1'b1);
        chk("t1_val1", val1, 32'd5);
        chk("t1_val2", val2, 32'd7);
        chk("t1_entry", entry, 4'd3);
        chk("t1_pc", nowPC, 32'h100);
        cycle();
        chk("t1_single_pulse", execute, 1'b0);

        // 2: operand 1 woken by a later ALU broadcast
        dispatch(addi, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0, 4'd6, 32'h104);
        cycle();
        idle();
        cycle();
        cycle();
        alu_ready = 1'b1; alu_entry = 4'd2; alu_val = 32'h10;
        cycle();
        chk("t2_not_yet", execute, 1'b0);
        idle();
        cycle();
        chk("t2_exec", execute, 1'b1);
        chk("t2_val1", val1, 32'h10);
        chk("t2_val2", val2, 32'd1);

        // 3: same-cycle LSB broadcast bypassed into dispatch
        dispatch(addi, 1'b1, 32'h22, 4'd0, 1'b0, 32'd0, 4'd5, 4'd8, 32'h108);
        lsb_ready = 1'b1; lsb_entry = 4'd5; lsb_val = 32'hAB;
        cycle();
        idle();
        cycle();
        chk("t3_exec", execute, 1'b1);
        chk("t3_val2", val2, 32'hAB);

        // 4: fill all slots, overflow dispatch dropped, drain in slot order
        for (int i = 0; i < RS; i++) begin
            dispatch(addi, 1'b0, 32'd0, 4'd7, 1'b1, 32'(i), 4'd0, 4'(i), 32'h200 + 32'(4 * i));
            cycle();
        end
        chk("t4_full", rs_full, 1'b1);
        dispatch(addi, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0, 4'd15, 32'h300);
        cycle();
        chk("t4_still_full", rs_full, 1'b1);
        idle();
        alu_ready = 1'b1; alu_entry = 4'd7; alu_val = 32'h77;
        cycle();
        idle();
        for (int i = 0; i < RS; i++) begin
            cycle();
            chk("t4_drain_exec", execute, 1'b1);
            chk("t4_drain_entry", entry, 4'(i));
        end
        cycle();
        chk("t4_done_exec", execute, 1'b0);
        chk("t4_done_full", rs_full, 1'b0);

        // 5: flush with a concurrent dispatch drops everything
        for (int i = 0; i < 4; i++) begin
            dispatch(addi, 1'b0, 32'd0, 4'd9, 1'b0, 32'd0, 4'd9, 4'(i), 32'h500);
            cycle();
        end
        dispatch(addi, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0, 4'd12, 32'h504);
        flush = 1'b1;
        cycle();
        chk("t5_exec", execute, 1'b0);
        chk("t5_full", rs_full, 1'b0);
        idle();
        alu_ready = 1'b1; alu_entry = 4'd9; alu_val = 32'h99;
        cycle();
        idle();
        cycle();
        chk("t5_no_issue_a", execute, 1'b0);
        cycle();
        chk("t5_no_issue_b", execute, 1'b0);

        // 6: freeze while a pulse is held
        dispatch(addi, 1'b1, 32'h41, 4'd0, 1'b1, 32'h42, 4'd0, 4'd4, 32'h600);
        cycle();
        dispatch(addi, 1'b1, 32'h51, 4'd0, 1'b1, 32'h52, 4'd0, 4'd5, 32'h604);
        cycle();
        chk("t6_exec", execute, 1'b1);
        chk("t6_entry", entry, 4'd4);
        idle();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t6_hold_exec", execute, 1'b1);
            chk("t6_hold_entry", entry, 4'd4);
            chk("t6_hold_pc", nowPC, 32'h600);
        end
        rdy_in = 1'b1;
        cycle();
        chk("t6_next_exec", execute, 1'b1);
        chk("t6_next_entry", entry, 4'd5);
        cycle();
        chk("t6_no_dup", execute, 1'b0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            rdy_in      = ($urandom_range(0, 9) != 0);
            flush       = ($urandom_range(0, 59) == 0);
            disp_valid  = ($urandom_range(0, 2) != 0) && !model_full();
            disp_type   = 7'($urandom);
            disp_q1_rdy = 1'($urandom_range(0, 1));
            disp_v1     = $urandom;
            disp_q1     = 4'($urandom_range(0, 3));
            disp_q2_rdy = 1'($urandom_range(0, 1));
            disp_v2     = $urandom;
            disp_q2     = 4'($urandom_range(0, 3));
            disp_entry  = 4'($urandom);
            disp_pc     = $urandom;
            alu_ready   = 1'($urandom_range(0, 1));
            alu_entry   = 4'($urandom_range(0, 4));
            alu_val     = $urandom;
            lsb_ready   = 1'($urandom_range(0, 1));
            lsb_entry   = 4'($urandom_range(0, 4));
            lsb_val     = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
